// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU-control decoder with MULT/DIV sequencing
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake carrying aluop and funct
//   out_valid/out_ready response handshake carrying alu_ctrl, is_muldiv, illegal
//   busy                a MULT/DIV is counting down
//   illegal_sticky      only when ALUCTL_STICKY_EN is defined; latches any accepted illegal op
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int FUNCT_W    = 6,
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               is_muldiv,
  output logic               illegal,
  output logic               busy
`ifdef ALUCTL_STICKY_EN
  ,output logic              illegal_sticky
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [3:0]       r_code;
  logic             r_md;
  logic             r_ill;
  logic             r_rdy_en;
  logic [3:0]       w_code;
  logic             w_md;
  logic             w_ill;
  logic             w_acc;
  always_comb begin
    w_code = 4'b1111;
    w_ill  = 1'b0;
    w_md   = 1'b0;
    if (aluop != 2'b10) begin
      w_code = (aluop == 2'b00) ? 4'b0010 : (aluop == 2'b01) ? 4'b0110 : 4'b0001;
    end else begin
      case (funct)
        FUNCT_W'(6'b100000): w_code = 4'b0010;
        FUNCT_W'(6'b100010): w_code = 4'b0110;
        FUNCT_W'(6'b100100): w_code = 4'b0000;
        FUNCT_W'(6'b100101): w_code = 4'b0001;
        FUNCT_W'(6'b100110): w_code = 4'b1001;
        FUNCT_W'(6'b100111): w_code = 4'b1100;
        FUNCT_W'(6'b101010): w_code = 4'b0111;
        FUNCT_W'(6'b000000): w_code = 4'b1000;
        FUNCT_W'(6'b000010): w_code = 4'b1011;
        FUNCT_W'(6'b011000): begin w_code = 4'b1101; w_md = 1'b1; end
        FUNCT_W'(6'b011010): begin w_code = 4'b1110; w_md = 1'b1; end
        default:             w_ill = 1'b1;
      endcase
    end
  end
  // r_rdy_en holds in_ready low during reset and for the first cycle after release
  assign in_ready  = r_rdy_en && (r_state == S_IDLE) && (!r_valid || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_valid;
  assign alu_ctrl  = CTRL_W'(r_code);
  assign is_muldiv = r_md;
  assign illegal   = r_ill;
  assign busy      = (r_state == S_BUSY);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_code   <= '0;
      r_md     <= 1'b0;
      r_ill    <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_code  <= w_code;
            r_md    <= w_md;
            r_ill   <= w_ill;
            r_valid <= !w_md;
            r_cnt   <= CNT_W'(MULDIV_LAT - 1);
            r_state <= w_md ? S_BUSY : S_IDLE;
          end else if (out_ready) begin
            r_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end
`ifdef ALUCTL_STICKY_EN
  logic r_sticky;
  assign illegal_sticky = r_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sticky <= 1'b0;
    else if (w_acc && w_ill) r_sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and random checks of alu_ctrl_seq against a transaction-level model
module tb_alu_ctrl_seq;
  localparam int LAT = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] aluop = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] alu_ctrl;
  logic       is_muldiv;
  logic       illegal;
  logic       busy;
`ifdef ALUCTL_STICKY_EN
  logic       illegal_sticky;
`endif
  int tests = 0;
  int fails = 0;
  logic [5:0] ftab [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                            6'b101010, 6'b000000, 6'b000010, 6'b011000, 6'b011010};
  logic [3:0] ctab [11] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1001, 4'b1100,
                            4'b0111, 4'b1000, 4'b1011, 4'b1101, 4'b1110};
  int         m_pend;
  logic       m_valid, m_md, m_ill, m_rdy, m_sticky;
  logic [3:0] m_code;
  logic       p_md, p_ill;
  logic [3:0] p_code;
  alu_ctrl_seq #(.CTRL_W(4), .FUNCT_W(6), .MULDIV_LAT(LAT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .is_muldiv(is_muldiv), .illegal(illegal), .busy(busy)
`ifdef ALUCTL_STICKY_EN
    , .illegal_sticky(illegal_sticky)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic decode(input logic [1:0] op, input logic [5:0] fn,
                        output logic [3:0] code, output logic md, output logic ill);
    md = 1'b0;
    ill = 1'b0;
    if (op == 2'b00) code = 4'b0010;
    else if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b11) code = 4'b0001;
    else begin
      code = 4'b1111;
      ill = 1'b1;
      for (int k = 0; k < 11; k++)
        if (ftab[k] == fn) begin
          code = ctab[k];
          ill = 1'b0;
          md = (k >= 9);
        end
    end
  endtask
  task automatic model_reset();
    m_pend = 0;
    m_valid = 1'b0;
    m_md = 1'b0;
    m_ill = 1'b0;
    m_code = 4'b0;
    m_rdy = 1'b0;
    m_sticky = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"}, {7'b0, out_valid}, 8'h0);
    chk({tag, ".in_ready"}, {7'b0, in_ready}, 8'h0);
    chk({tag, ".alu_ctrl"}, {4'b0, alu_ctrl}, 8'h0);
    chk({tag, ".is_muldiv"}, {7'b0, is_muldiv}, 8'h0);
    chk({tag, ".illegal"}, {7'b0, illegal}, 8'h0);
    chk({tag, ".busy"}, {7'b0, busy}, 8'h0);
`ifdef ALUCTL_STICKY_EN
    chk({tag, ".sticky"}, {7'b0, illegal_sticky}, 8'h0);
`endif
  endtask
  // Called just after a falling edge; drives, checks, then runs one rising edge through the model.
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic ordy);
    logic exp_rdy, acc;
    in_valid = v;
    aluop = op;
    funct = fn;
    out_ready = ordy;
    #1;
    exp_rdy = m_rdy && (m_pend == 0) && !(m_valid && m_md) && (!m_valid || ordy);
    chk("in_ready", {7'b0, in_ready}, {7'b0, exp_rdy});
    chk("busy", {7'b0, busy}, {7'b0, m_pend > 0});
    chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
    if (m_valid) begin
      chk("alu_ctrl", {4'b0, alu_ctrl}, {4'b0, m_code});
      chk("is_muldiv", {7'b0, is_muldiv}, {7'b0, m_md});
      chk("illegal", {7'b0, illegal}, {7'b0, m_ill});
    end
`ifdef ALUCTL_STICKY_EN
    chk("sticky", {7'b0, illegal_sticky}, {7'b0, m_sticky});
`endif
    acc = v && exp_rdy;
    decode(op, fn, p_code, p_md, p_ill);
    @(posedge clk);
    m_rdy = 1'b1;
    if (m_valid && ordy) m_valid = 1'b0;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) m_valid = 1'b1;
    end
    if (acc) begin
      m_code = p_code;
      m_md = p_md;
      m_ill = p_ill;
      m_sticky = m_sticky | p_ill;
      if (p_md) m_pend = LAT;
      else m_valid = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 6'b0, ordy);
  endtask
  initial begin
    model_reset();
    #1;
    check_reset("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1);
    step(1'b1, 2'b10, 6'b100000, 1'b1);
    step(1'b1, 2'b10, 6'b100010, 1'b1);
    step(1'b1, 2'b10, 6'b100100, 1'b1);
    chk("stream_last", {4'b0, alu_ctrl}, 8'h00);
    idle(1, 1'b1);
    step(1'b1, 2'b10, 6'b011000, 1'b1);
    for (int k = 0; k < LAT; k++) step(1'b1, 2'b10, 6'b100000, 1'b1);
    chk("mult_code", {4'b0, alu_ctrl}, 8'h0d);
    step(1'b1, 2'b10, 6'b100000, 1'b1);
    step(1'b1, 2'b10, 6'b101010, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b00, 6'b0, 1'b0);
    chk("slt_held", {4'b0, alu_ctrl}, 8'h07);
    step(1'b0, 2'b00, 6'b0, 1'b1);
    step(1'b1, 2'b10, 6'b111111, 1'b1);
    step(1'b1, 2'b00, 6'b111111, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 2'b10, 6'b011010, 1'b1);
    idle(LAT, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 2'b11, 6'b0, 1'b1);
    step(1'b1, 2'b11, 6'b0, 1'b1);
    step(1'b1, 2'b01, 6'b0, 1'b1);
    idle(2, 1'b1);
    for (int n = 0; n < 800; n++) begin
      logic [5:0] fn;
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 10)];
      step($urandom_range(0, 9) < 6, 2'($urandom), fn, $urandom_range(0, 9) < 7);
    end
    idle(LAT + 4, 1'b1);
    step(1'b1, 2'b10, 6'b011010, 1'b1);
    idle(3, 1'b1);
    chk("busy_before_rst", {7'b0, busy}, 8'h1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid_busy");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 4, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, handshaked successor to the combinational ALU-control decoder.
- Accepts {aluop, funct} from the decode stage and produces a CTRL_W-bit ALU control code.
- Adds multi-cycle sequencing for MULT/DIV: holds busy for MULDIV_LAT cycles, then emits the code.
- Sits between the ID/EX pipeline register and the ALU/mult-div unit; backpressure comes from the EX stage.

Parameters:
- CTRL_W, 4, width of ALU control code (minimum 4; codes are zero-extended above bit 3).
- FUNCT_W, 6, width of funct field.
- MULDIV_LAT, 8, busy cycles for MULT/DIV (1..255).
- CNT_W, 8, busy counter width; must satisfy 2^CNT_W > MULDIV_LAT.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, block can accept a request.
- aluop, input, 2, main-control ALU op class.
- funct, input, FUNCT_W, instruction funct field.
- out_valid, output, 1, alu_ctrl valid.
- out_ready, input, 1, consumer accepts the output.
- alu_ctrl, output, CTRL_W, ALU control code.
- is_muldiv, output, 1, the current output is a multi-cycle op.
- illegal, output, 1, the current output came from an undefined funct.
- busy, output, 1, a multi-cycle op is in progress.
- illegal_sticky, output, 1, present only with ALUCTL_STICKY_EN.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - out_valid=0, alu_ctrl=0, is_muldiv=0, illegal=0, busy=0, counter=0.
  - in_ready=1 one cycle after deassert.
- Decode:
  - aluop 00 → ADD 0010.
  - aluop 01 → SUB 0110.
  - aluop 11 → OR 0001.
  - aluop 10 → decode funct:
    - 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001.
    - 100110 XOR 1001; 100111 NOR 1100; 101010 SLT 0111.
    - 000000 SLL 1000; 000010 SRL 1011.
    - 011000 MULT 1101; 011010 DIV 1110.
    - Any other funct → 1111 with illegal=1.
  - funct is ignored for aluop 00/01/11.
- Handshake:
  - Transfer occurs when valid && ready in the same cycle.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid, alu_ctrl, is_muldiv and illegal stay stable while out_valid && !out_ready.
- State IDLE:
  - Single-cycle op accepted → output registered next cycle (latency 1); stay in IDLE.
  - MULT/DIV accepted → go to BUSY; load counter=MULDIV_LAT-1; busy=1; out_valid stays 0.
- State BUSY:
  - in_ready=0; counter decrements each cycle.
  - At counter==0 → go to DONE.
  - Total latency from accept to out_valid = MULDIV_LAT+1 cycles.
- State DONE:
  - out_valid=1, alu_ctrl=MULT/DIV code, is_muldiv=1, busy=0.
  - Hold until out_ready, then go to IDLE.
  - DONE does not accept new input in the cycle it is drained; the next request is accepted the following cycle.
- Output pipelining: back-to-back single-cycle ops sustain 1 op/cycle when out_ready=1.
- Boundary conditions:
  - MULDIV_LAT=1: BUSY lasts exactly 1 cycle.
  - in_valid is ignored while in BUSY or DONE.
  - An illegal op is a single-cycle op.
  - rst_n low mid-BUSY: immediate return to reset values; the op is discarded, no output.
  - An X/unknown aluop never yields out_valid without a preceding accept.

Optional Feature:
- Macro: ALUCTL_STICKY_EN.
- Defined:
  - Output port illegal_sticky is present.
  - Set in the cycle after any accepted illegal op.
  - Cleared only by rst_n.
  - Stays set through subsequent legal ops.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 → all outputs 0; release rst_n → in_ready=1 one cycle later.
- Stream, out_ready=1: aluop=10 with funct 100000, 100010, 100100 on consecutive cycles → alu_ctrl 0010, 0110, 0000 on consecutive cycles, each 1 cycle after accept.
- MULT, MULDIV_LAT=8: aluop=10, funct=011000 → busy=1 and in_ready=0 for 8 cycles; out_valid=1 with alu_ctrl=1101 and is_muldiv=1 at cycle 9.
- Backpressure: out_ready=0 for 3 cycles after an SLT accept → alu_ctrl=0111 held stable, in_ready=0; release → in_ready returns to 1.
- Illegal: aluop=10, funct=111111 → alu_ctrl=1111, illegal=1; with ALUCTL_STICKY_EN, illegal_sticky stays 1 after a following ADD.
- Reset mid-BUSY: DIV accepted, rst_n=0 at busy cycle 4 → out_valid never asserts; busy=0 immediately.
